// File: rtl/scanline_pos_gen_pkg.sv
// rtl/scanline_pos_gen_pkg.sv - shared constants and types for scanline position generation
package scanline_pos_gen_pkg;

  // Fractional bits of the vertical phase accumulator (1.0 == 1 << ACC_W)
  localparam int ACC_W_DEF = 12;

  // Width and reset value of the scanline position handed to scanline emulation
  localparam int                   SL_POS_W   = 8;
  localparam logic [SL_POS_W-1:0]  SL_POS_MID = 8'h80;

  // RGB pixel width carried through the video path
  localparam int VDATA_W = 24;

  typedef enum logic {
    WAIT_VS = 1'b0,
    ACTIVE  = 1'b1
  } sl_state_e;

endpackage

// File: rtl/scanline_pos_gen.sv
// rtl/scanline_pos_gen.sv - per-line scanline position/enable with matched 2-cycle video delay
module scanline_pos_gen
  import scanline_pos_gen_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                VCLK_i,
  input  logic                nVRST_i,
  input  logic                HSYNC_i,
  input  logic                VSYNC_i,
  input  logic                DE_i,
  input  logic [VDATA_W-1:0]  vdata_i,
  input  logic                sl_en_i,
  input  logic [ACC_W:0]      v_step_i,
  input  logic [ACC_W-1:0]    v_phase_init_i,
  output logic                HSYNC_o,
  output logic                VSYNC_o,
  output logic                DE_o,
  output logic [VDATA_W-1:0]  vdata_o,
  output logic                sl_en_o,
  output logic [SL_POS_W-1:0] sl_rel_pos_o
);

  localparam logic [ACC_W:0] STEP_ONE = {1'b1, {ACC_W{1'b0}}};

  // First video stage; the second stage is the output registers themselves
  logic               hs_d1, vs_d1, de_d1;
  logic [VDATA_W-1:0] vdata_d1;

  sl_state_e          state, state_nxt;
  logic               sl_allowed;

  logic [ACC_W:0]     step_sh;
  logic [ACC_W-1:0]   acc;

  logic               fs, ls, le;
  logic [ACC_W:0]     step_src;
  logic [ACC_W-1:0]   acc_src;
  logic [ACC_W-1:0]   pos_sum;
  logic               unused_pos_lsbs;

  // Events compare stage 1 against stage 2 so LS lands on the DE_o rising edge
  assign fs = VSYNC_o & ~vs_d1;
  assign ls = de_d1 & ~DE_o;
  assign le = ~de_d1 & DE_o;

  // A frame start in the same cycle as a line start hands that line the fresh config
  assign step_src = fs ? v_step_i : step_sh;
  assign acc_src  = fs ? v_phase_init_i : acc;
  assign pos_sum  = acc_src + step_src[ACC_W:1];

  // Only the top bits of the line centre matter; the rest is carry fodder
  assign unused_pos_lsbs = ^pos_sum[ACC_W-SL_POS_W-1:0];

  // Two-stage video delay line; reset values double as cleared edge-detector history
  always_ff @(posedge VCLK_i) begin
    if (!nVRST_i) begin
      hs_d1    <= 1'b1;
      vs_d1    <= 1'b1;
      de_d1    <= 1'b0;
      vdata_d1 <= '0;
      HSYNC_o  <= 1'b1;
      VSYNC_o  <= 1'b1;
      DE_o     <= 1'b0;
      vdata_o  <= '0;
    end else begin
      hs_d1    <= HSYNC_i;
      vs_d1    <= VSYNC_i;
      de_d1    <= DE_i;
      vdata_d1 <= vdata_i;
      HSYNC_o  <= hs_d1;
      VSYNC_o  <= vs_d1;
      DE_o     <= de_d1;
      vdata_o  <= vdata_d1;
    end
  end

  // State register
  always_ff @(posedge VCLK_i) begin
    if (!nVRST_i) state <= WAIT_VS;
    else          state <= state_nxt;
  end

  // Next state: first frame start arms scanlines for good
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_VS: if (fs) state_nxt = ACTIVE;
      ACTIVE:  state_nxt = ACTIVE;
      default: state_nxt = WAIT_VS;
    endcase
  end

  // Output decode: a line may carry scanlines once a frame start has been seen
  always_comb begin
    sl_allowed = 1'b0;
    case (state)
      WAIT_VS: sl_allowed = fs;
      ACTIVE:  sl_allowed = 1'b1;
      default: sl_allowed = 1'b0;
    endcase
  end

  // Phase accumulator: reload at frame start, advance one output line at line end
  always_ff @(posedge VCLK_i) begin
    if (!nVRST_i) begin
      acc     <= '0;
      step_sh <= STEP_ONE;
    end else if (fs) begin
      acc     <= v_phase_init_i;
      step_sh <= v_step_i;
    end else if (le) begin
      acc     <= acc + step_sh[ACC_W-1:0];
    end
  end

  // Per-line scanline outputs, held from one line start to the next
  always_ff @(posedge VCLK_i) begin
    if (!nVRST_i) begin
      sl_rel_pos_o <= SL_POS_MID;
      sl_en_o      <= 1'b0;
    end else if (ls) begin
      sl_rel_pos_o <= pos_sum[ACC_W-1 -: SL_POS_W];
      sl_en_o      <= sl_en_i & sl_allowed & (step_src < STEP_ONE);
    end
  end

endmodule

// File: tb/tb_scanline_pos_gen.sv
// tb/tb_scanline_pos_gen.sv - self-checking bench for scanline_pos_gen
module tb_scanline_pos_gen;
  import scanline_pos_gen_pkg::*;

  logic               VCLK_i = 1'b0;
  logic               nVRST_i;
  logic               HSYNC_i, VSYNC_i, DE_i, sl_en_i;
  logic [VDATA_W-1:0] vdata_i;
  logic [12:0]        v_step_i;
  logic [11:0]        v_phase_init_i;
  logic               HSYNC_o, VSYNC_o, DE_o, sl_en_o;
  logic [VDATA_W-1:0] vdata_o;
  logic [7:0]         sl_rel_pos_o;

  scanline_pos_gen #(.ACC_W(12)) dut (
    .VCLK_i(VCLK_i), .nVRST_i(nVRST_i),
    .HSYNC_i(HSYNC_i), .VSYNC_i(VSYNC_i), .DE_i(DE_i), .vdata_i(vdata_i),
    .sl_en_i(sl_en_i), .v_step_i(v_step_i), .v_phase_init_i(v_phase_init_i),
    .HSYNC_o(HSYNC_o), .VSYNC_o(VSYNC_o), .DE_o(DE_o), .vdata_o(vdata_o),
    .sl_en_o(sl_en_o), .sl_rel_pos_o(sl_rel_pos_o)
  );

  always #5 VCLK_i = ~VCLK_i;

  typedef struct packed {
    logic [7:0] pos;
    logic       en;
  } exp_t;

  typedef struct packed {
    logic [12:0]      step;
    logic [11:0]      phase;
    logic             sl_en;
    logic [3:0][7:0]  pos;   // line 0 in [3]
    logic             en;
  } vec_t;

  exp_t  sb[$];
  vec_t  vecs[7];
  int    n_checks = 0;
  int    n_errs   = 0;
  bit    vid_chk  = 1'b0;
  logic  de_o_prev = 1'b0;
  logic [26:0] h1 = '0, h2 = '0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge VCLK_i);
    #1;
    vdata_i = VDATA_W'($urandom);
  endtask

  task automatic push(input logic [7:0] pos, input logic en);
    exp_t e;
    e.pos = pos;
    e.en  = en;
    sb.push_back(e);
  endtask

  task automatic hs_pulse();
    HSYNC_i = 1'b0;
    tick(); tick();
    HSYNC_i = 1'b1;
    tick(); tick();
  endtask

  task automatic do_line(input logic [7:0] pos, input logic en);
    hs_pulse();
    DE_i = 1'b1;
    push(pos, en);
    repeat (8) tick();
    DE_i = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_fs();
    VSYNC_i = 1'b0;
    tick(); tick();
    VSYNC_i = 1'b1;
    tick(); tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    @(negedge VCLK_i);
    chk({tag, "_hsync"}, int'(HSYNC_o), 1);
    chk({tag, "_vsync"}, int'(VSYNC_o), 1);
    chk({tag, "_de"},    int'(DE_o), 0);
    chk({tag, "_vdata"}, int'(vdata_o), 0);
    chk({tag, "_sl_en"}, int'(sl_en_o), 0);
    chk({tag, "_pos"},   int'(sl_rel_pos_o), 'h80);
  endtask

  // Scoreboard pop at each DE_o rise, plus bit-exact 2-cycle video path check
  always @(negedge VCLK_i) begin
    exp_t e;
    if (DE_o && !de_o_prev) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sl_rel_pos", int'(sl_rel_pos_o), int'(e.pos));
        chk("sl_en", int'(sl_en_o), int'(e.en));
      end
    end
    de_o_prev = DE_o;
    if (vid_chk)
      chk("video_path", int'({HSYNC_o, VSYNC_o, DE_o, vdata_o}), int'(h2));
    h2 = h1;
    h1 = {HSYNC_i, VSYNC_i, DE_i, vdata_i};
  end

  initial begin
    vecs[0] = '{13'h0800, 12'h000, 1'b1, {8'h40, 8'hC0, 8'h40, 8'hC0}, 1'b1};
    vecs[1] = '{13'h0555, 12'h000, 1'b1, {8'h2A, 8'h7F, 8'hD5, 8'h2A}, 1'b1};
    vecs[2] = '{13'h1000, 12'h000, 1'b1, {8'h80, 8'h80, 8'h80, 8'h80}, 1'b0};
    vecs[3] = '{13'h1800, 12'h000, 1'b1, {8'hC0, 8'h40, 8'hC0, 8'h40}, 1'b0};
    vecs[4] = '{13'h0800, 12'h100, 1'b1, {8'h50, 8'hD0, 8'h50, 8'hD0}, 1'b1};
    vecs[5] = '{13'h0000, 12'h345, 1'b1, {8'h34, 8'h34, 8'h34, 8'h34}, 1'b1};
    vecs[6] = '{13'h0800, 12'h000, 1'b0, {8'h40, 8'hC0, 8'h40, 8'hC0}, 1'b0};

    nVRST_i = 1'b0;
    HSYNC_i = 1'b1; VSYNC_i = 1'b1; DE_i = 1'b0; sl_en_i = 1'b1;
    vdata_i = '0; v_step_i = 13'h0800; v_phase_init_i = '0;

    // Reset held with random inputs
    repeat (6) begin
      tick();
      HSYNC_i = 1'($urandom); VSYNC_i = 1'($urandom); DE_i = 1'($urandom);
      sl_en_i = 1'($urandom); v_step_i = 13'($urandom); v_phase_init_i = 12'($urandom);
    end
    HSYNC_i = 1'b1; VSYNC_i = 1'b1; DE_i = 1'b1; sl_en_i = 1'b1;
    v_step_i = 13'h0800; v_phase_init_i = '0;
    tick();
    chk_reset_vals("rst");

    // Release with DE already high: LS seen while still waiting for VSYNC
    tick();
    nVRST_i = 1'b1;
    push(8'h80, 1'b0);
    repeat (6) tick();
    DE_i = 1'b0;
    repeat (4) tick();
    vid_chk = 1'b1;
    do_line(8'h80, 1'b0);

    // Table-driven frames
    for (int i = 0; i < 7; i++) begin
      v_step_i = vecs[i].step;
      v_phase_init_i = vecs[i].phase;
      sl_en_i = vecs[i].sl_en;
      do_fs();
      for (int j = 0; j < 4; j++) do_line(vecs[i].pos[3-j], vecs[i].en);
    end

    // Mid-frame config change only takes effect at the next frame
    sl_en_i = 1'b1; v_step_i = 13'h0800; v_phase_init_i = 12'h000;
    do_fs();
    do_line(8'h40, 1'b1);
    do_line(8'hC0, 1'b1);
    v_step_i = 13'h0555;
    do_line(8'h40, 1'b1);
    do_line(8'hC0, 1'b1);
    do_fs();
    do_line(8'h2A, 1'b1);
    do_line(8'h7F, 1'b1);

    // FS coincident with LS: line uses the new phase and step
    v_step_i = 13'h0800; v_phase_init_i = 12'h200;
    hs_pulse();
    VSYNC_i = 1'b0; DE_i = 1'b1;
    push(8'h60, 1'b1);
    repeat (4) tick();
    VSYNC_i = 1'b1;
    repeat (4) tick();
    DE_i = 1'b0;
    repeat (3) tick();
    do_line(8'hE0, 1'b1);

    // FS coincident with LE: accumulator reloads instead of advancing
    v_phase_init_i = 12'h000;
    hs_pulse();
    DE_i = 1'b1;
    push(8'h60, 1'b1);
    repeat (8) tick();
    DE_i = 1'b0; VSYNC_i = 1'b0;
    tick(); tick();
    VSYNC_i = 1'b1;
    repeat (3) tick();
    do_line(8'h40, 1'b1);

    // Reset mid-line, released with DE still high
    hs_pulse();
    DE_i = 1'b1;
    push(8'hC0, 1'b1);
    repeat (5) tick();
    vid_chk = 1'b0;
    nVRST_i = 1'b0;
    tick();
    chk_reset_vals("midrst");
    tick();
    nVRST_i = 1'b1;
    push(8'h80, 1'b0);
    repeat (6) tick();
    DE_i = 1'b0;
    repeat (3) tick();
    vid_chk = 1'b1;
    do_line(8'h80, 1'b0);
    do_fs();
    do_line(8'h40, 1'b1);

    repeat (5) tick();
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
